// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared WS2812B timing defaults, ns-to-cycle helper and rx state type
package ws2812b_pkg;

    // Nominal line timing shared with the transmitter side, in ns.
    localparam int T0H_NS  = 400;
    localparam int T1H_NS  = 800;
    localparam int T0L_NS  = 850;
    localparam int T1L_NS  = 450;
    localparam int TRST_NS = 50000;

    // Whole clock periods in a duration; the clock period itself is truncated to whole ns.
    function automatic int ns_to_cycles(input int ns, input int fclk_mhz);
        return ns / (1000 / fclk_mhz);
    endfunction

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } rx_state_e;

endpackage

// File: rtl/ws2812b_sync.sv
// rtl/ws2812b_sync.sv - two-flop synchronizer for the data line with rise/fall strobes
module ws2812b_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two metastability flops, then one more stage to compare against for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812b_rx.sv
// rtl/ws2812b_rx.sv - WS2812B stream decoder: pulse classification, word assembly, frame reset
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int FCLK         = 100,
    parameter int T_BIT_THRESH = 625,
    parameter int T_HIGH_MIN   = 150,
    parameter int T_HIGH_MAX   = 1250,
    parameter int T_RST_DET    = 50000,
    parameter int MAX_LEDS     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] pixel,
    output logic [31:0] pixel_idx,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [31:0] frame_len,
    output logic        bit_err
);

    localparam int C_TH  = ns_to_cycles(T_BIT_THRESH, FCLK);
    localparam int C_MIN = ns_to_cycles(T_HIGH_MIN, FCLK);
    localparam int C_MAX = ns_to_cycles(T_HIGH_MAX, FCLK);
    localparam int C_RST = ns_to_cycles(T_RST_DET, FCLK);
    localparam int CW    = $clog2(C_RST) + 1;
    localparam int WCW   = $clog2(MAX_LEDS) + 1;

    localparam logic [CW-1:0]  TH_C    = CW'(C_TH);
    localparam logic [CW-1:0]  MIN_C   = CW'(C_MIN);
    localparam logic [CW-1:0]  MAX_C   = CW'(C_MAX);
    localparam logic [CW-1:0]  RST_C   = CW'(C_RST);
    localparam logic [WCW-1:0] LEDS_C  = WCW'(MAX_LEDS);

    logic level, rise, fall, line_edge, bit_val;

    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [23:0]     shift_q, shift_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]  word_cnt_q, word_cnt_d;
    logic [23:0]     pixel_q, pixel_d;
    logic [31:0]     pixel_idx_q, pixel_idx_d;
    logic [31:0]     frame_len_q, frame_len_d;
    logic            pixel_valid_q, pixel_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            bit_err_q, bit_err_d;

    ws2812b_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_i   (din),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign line_edge = rise | fall;
    assign bit_val   = (cnt_q >= TH_C);

    // Time since the last edge; the edge cycle is the first sample of the new level.
    always_comb begin
        cnt_d = cnt_q;
        if (line_edge) begin
            cnt_d = CW'(1);
        end else if (cnt_q != RST_C) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a reset-length low that ends on a rise goes straight into a new bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC: if (!level && !line_edge && cnt_q == RST_C) state_d = IDLE;
            IDLE: if (rise) state_d = HIGH;
            HIGH: begin
                if (fall) begin
                    state_d = (cnt_q < MIN_C) ? SYNC : LOW;
                end else if (cnt_q >= MAX_C) begin
                    state_d = SYNC;
                end
            end
            LOW: begin
                if (cnt_q == RST_C) begin
                    state_d = rise ? HIGH : IDLE;
                end else if (rise) begin
                    state_d = HIGH;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // Datapath updates and output strobes for the current state and line events.
    always_comb begin
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        pixel_d       = pixel_q;
        pixel_idx_d   = pixel_idx_q;
        frame_len_d   = frame_len_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        bit_err_d     = 1'b0;
        case (state_q)
            SYNC, IDLE: begin
                bit_cnt_d  = '0;
                word_cnt_d = '0;
            end
            HIGH: begin
                if (fall) begin
                    if (cnt_q < MIN_C) begin
                        bit_err_d  = 1'b1;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                    end else begin
                        shift_d = {shift_q[22:0], bit_val};
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            if (word_cnt_q < LEDS_C) begin
                                pixel_d       = {shift_q[22:0], bit_val};
                                pixel_idx_d   = 32'(word_cnt_q);
                                pixel_valid_d = 1'b1;
                                word_cnt_d    = word_cnt_q + WCW'(1);
                            end else begin
                                bit_err_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (cnt_q >= MAX_C) begin
                    bit_err_d = 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == RST_C) begin
                    frame_done_d = 1'b1;
                    frame_len_d  = 32'(word_cnt_q);
                    bit_err_d    = (bit_cnt_q != 5'd0);
                    bit_cnt_d    = '0;
                    word_cnt_d   = '0;
                end
            end
            default: begin
                bit_cnt_d  = '0;
                word_cnt_d = '0;
            end
        endcase
    end

    // Counter, shift register, word bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            pixel_q       <= '0;
            pixel_idx_q   <= '0;
            frame_len_q   <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            bit_err_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            pixel_q       <= pixel_d;
            pixel_idx_q   <= pixel_idx_d;
            frame_len_q   <= frame_len_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            bit_err_q     <= bit_err_d;
        end
    end

    assign pixel       = pixel_q;
    assign pixel_idx   = pixel_idx_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_len   = frame_len_q;
    assign bit_err     = bit_err_q;

endmodule

// File: tb/tb_ws2812b_rx.sv
// tb/tb_ws2812b_rx.sv - self-checking bench for ws2812b_rx with a pulse-level reference model
module tb_ws2812b_rx;

    localparam int TCLK     = 10;
    localparam int C_TH     = 625 / TCLK;
    localparam int C_MIN    = 150 / TCLK;
    localparam int C_MAX    = 1250 / TCLK;
    localparam int C_RST    = 50000 / TCLK;
    localparam int MAX_LEDS = 256;
    localparam int EDGE_LAT = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        din   = 1'b0;
    logic [23:0] pixel;
    logic [31:0] pixel_idx;
    logic        pixel_valid;
    logic        frame_done;
    logic [31:0] frame_len;
    logic        bit_err;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [55:0] got_px[$];
    logic [55:0] exp_px[$];
    int          got_fd[$];
    int          exp_fd[$];
    int          got_err = 0;
    int          exp_err = 0;
    int          err_cyc = 0;
    int          fd_cyc  = 0;
    int          px_cyc  = 0;

    bit          m_sync    = 1'b0;
    bit          m_inframe = 1'b0;
    int          m_bits    = 0;
    int          m_words   = 0;
    logic [23:0] m_word    = '0;

    ws2812b_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .pixel       (pixel),
        .pixel_idx   (pixel_idx),
        .pixel_valid (pixel_valid),
        .frame_done  (frame_done),
        .frame_len   (frame_len),
        .bit_err     (bit_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pixel_valid) begin
                got_px.push_back({pixel_idx, pixel});
                px_cyc = cyc;
            end
            if (frame_done) begin
                got_fd.push_back(int'(frame_len));
                fd_cyc = cyc;
            end
            if (bit_err) begin
                got_err++;
                err_cyc = cyc;
            end
            if (pixel_valid && frame_done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe_overlap pixel_valid=%0b frame_done=%0b required not both at cycle %0d",
                         pixel_valid, frame_done, cyc);
            end
        end
    end

    task automatic model_reset();
        m_sync    = 1'b0;
        m_inframe = 1'b0;
        m_bits    = 0;
        m_words   = 0;
    endtask

    task automatic clear_obs();
        got_px.delete();
        exp_px.delete();
        got_fd.delete();
        exp_fd.delete();
        got_err = 0;
        exp_err = 0;
    endtask

    // One constant-level stretch of the line; the model reacts to whole pulses only.
    task automatic seg(input bit lvl, input int n);
        if (lvl) begin
            if (m_sync) begin
                if (n < C_MIN || n > C_MAX) begin
                    exp_err++;
                    m_sync    = 1'b0;
                    m_inframe = 1'b0;
                    m_bits    = 0;
                    m_words   = 0;
                end else begin
                    m_word    = {m_word[22:0], (n >= C_TH)};
                    m_bits++;
                    m_inframe = 1'b1;
                    if (m_bits == 24) begin
                        m_bits = 0;
                        if (m_words < MAX_LEDS) begin
                            exp_px.push_back({32'(m_words), m_word});
                            m_words++;
                        end else begin
                            exp_err++;
                        end
                    end
                end
            end
        end else if (n >= C_RST) begin
            if (m_sync && m_inframe) begin
                exp_fd.push_back(m_words);
                if (m_bits != 0) exp_err++;
            end
            m_sync    = 1'b1;
            m_inframe = 1'b0;
            m_bits    = 0;
            m_words   = 0;
        end
        din = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        if (b) seg(1'b1, int'($urandom_range(90, 70)));
        else   seg(1'b1, int'($urandom_range(45, 30)));
        seg(1'b0, int'($urandom_range(30, 20)));
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pixel, pixel_idx, pixel_valid, frame_done, frame_len, bit_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got pixel=%h idx=%0d pv=%0b fd=%0b len=%0d err=%0b required all 0",
                     pixel, pixel_idx, pixel_valid, frame_done, frame_len, bit_err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_obs();
    endtask

    task automatic test_single_word();
        logic [23:0] w;
        w = 24'h00FF00;
        clear_obs();
        seg(1'b0, C_RST + 100);
        for (int i = 23; i >= 0; i--) begin
            if (w[i]) begin seg(1'b1, 85); seg(1'b0, 40); end
            else      begin seg(1'b1, 40); seg(1'b0, 85); end
        end
        seg(1'b0, C_RST + 100);
        n_cmp++;
        if (got_px.size() != 1 || exp_px.size() != 1) begin
            n_bad++;
            $display("FAIL single_px_count got=%0d model=%0d required 1", got_px.size(), exp_px.size());
        end else begin
            n_cmp++;
            if (got_px[0] !== {32'd0, 24'h00FF00}) begin
                n_bad++;
                $display("FAIL single_px got=%h required=%h", got_px[0], {32'd0, 24'h00FF00});
            end
        end
        n_cmp++;
        if (got_fd.size() != 1 || got_fd[0] != 1) begin
            n_bad++;
            $display("FAIL single_frame got_count=%0d required one frame_done with frame_len=1", got_fd.size());
        end
        n_cmp++;
        if (got_err != 0) begin
            n_bad++;
            $display("FAIL single_err got=%0d required=0", got_err);
        end
        n_cmp++;
        if (fd_cyc - px_cyc < C_RST) begin
            n_bad++;
            $display("FAIL single_gap got=%0d cycles required >= %0d", fd_cyc - px_cyc, C_RST);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] words [5];
        words = '{24'hFF0000, 24'h555555, 24'h555555, 24'h555555, 24'hFF0000};
        clear_obs();
        for (int k = 0; k < 5; k++) send_word(words[k]);
        seg(1'b0, C_RST + 100);
        n_cmp++;
        if (got_px.size() != 5) begin
            n_bad++;
            $display("FAIL b2b_px_count got=%0d required=5", got_px.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (got_px[k] !== {32'(k), words[k]} || got_px[k] !== exp_px[k]) begin
                    n_bad++;
                    $display("FAIL b2b_px%0d got=%h required=%h", k, got_px[k], {32'(k), words[k]});
                end
            end
        end
        n_cmp++;
        if (got_fd.size() != 1 || got_fd[0] != 5) begin
            n_bad++;
            $display("FAIL b2b_frame got_count=%0d required one frame_done with frame_len=5", got_fd.size());
        end
    endtask

    task automatic test_mid_stream();
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_obs();
        for (int k = 0; k < 10; k++) send_bit(1'($urandom));
        n_cmp++;
        if (got_px.size() != 0 || got_err != 0) begin
            n_bad++;
            $display("FAIL mid_early got_px=%0d got_err=%0d required 0 and 0", got_px.size(), got_err);
        end
        seg(1'b0, C_RST + 100);
        send_word(24'($urandom));
        seg(1'b0, C_RST + 100);
        n_cmp++;
        if (got_px.size() != exp_px.size() || got_px.size() != 1 || got_px[0] !== exp_px[0]) begin
            n_bad++;
            $display("FAIL mid_px got_count=%0d model_count=%0d", got_px.size(), exp_px.size());
        end
        n_cmp++;
        if (got_fd.size() != 1 || got_fd[0] != 1) begin
            n_bad++;
            $display("FAIL mid_frame got_count=%0d required one frame_done with frame_len=1", got_fd.size());
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        for (int k = 0; k < 8; k++) send_bit(1'($urandom));
        seg(1'b1, 10);
        seg(1'b0, 40);
        for (int k = 0; k < 5; k++) send_bit(1'($urandom));
        seg(1'b0, C_RST + 100);
        n_cmp++;
        if (got_err != 1 || got_px.size() != 0 || got_fd.size() != 0) begin
            n_bad++;
            $display("FAIL glitch_drop got_err=%0d got_px=%0d got_fd=%0d required 1 0 0",
                     got_err, got_px.size(), got_fd.size());
        end
        send_word(24'($urandom));
        seg(1'b0, C_RST + 100);
        n_cmp++;
        if (got_px.size() != 1 || exp_px.size() != 1 || got_px[0] !== exp_px[0]) begin
            n_bad++;
            $display("FAIL glitch_recover got_count=%0d model_count=%0d", got_px.size(), exp_px.size());
        end
        n_cmp++;
        if (got_err != exp_err || got_fd.size() != exp_fd.size()) begin
            n_bad++;
            $display("FAIL glitch_totals got_err=%0d model_err=%0d got_fd=%0d model_fd=%0d",
                     got_err, exp_err, got_fd.size(), exp_fd.size());
        end
    endtask

    task automatic test_partial_and_stuck();
        int hs;
        clear_obs();
        for (int k = 0; k < 12; k++) send_bit(1'($urandom));
        seg(1'b0, C_RST + 100);
        n_cmp++;
        if (got_fd.size() != 1 || got_fd[0] != 0 || got_err != 1) begin
            n_bad++;
            $display("FAIL partial_frame got_fd=%0d got_err=%0d required one frame_done len 0 and one bit_err",
                     got_fd.size(), got_err);
        end
        n_cmp++;
        if (err_cyc != fd_cyc) begin
            n_bad++;
            $display("FAIL partial_same_cycle got err@%0d fd@%0d required equal", err_cyc, fd_cyc);
        end
        hs = cyc;
        seg(1'b1, 200);
        n_cmp++;
        if (got_err != 2 || err_cyc - hs != C_MAX + EDGE_LAT) begin
            n_bad++;
            $display("FAIL stuck_high got_err=%0d latency=%0d required 2 and %0d",
                     got_err, err_cyc - hs, C_MAX + EDGE_LAT);
        end
        seg(1'b0, C_RST + 100);
        n_cmp++;
        if (got_err != exp_err || got_fd.size() != exp_fd.size() || got_px.size() != 0) begin
            n_bad++;
            $display("FAIL partial_totals got_err=%0d model_err=%0d got_fd=%0d model_fd=%0d",
                     got_err, exp_err, got_fd.size(), exp_fd.size());
        end
    endtask

    task automatic test_boundaries();
        clear_obs();
        seg(1'b1, C_TH);      seg(1'b0, 30);
        seg(1'b1, C_TH - 1);  seg(1'b0, 30);
        seg(1'b1, C_MAX);     seg(1'b0, 30);
        seg(1'b1, C_MIN);     seg(1'b0, C_RST - 1);
        for (int k = 0; k < 19; k++) send_bit(1'($urandom));
        seg(1'b1, 40);
        seg(1'b0, C_RST);
        send_word(24'($urandom));
        seg(1'b0, C_RST + 100);
        n_cmp++;
        if (got_px.size() != 2 || exp_px.size() != 2) begin
            n_bad++;
            $display("FAIL bound_px_count got=%0d model=%0d required 2", got_px.size(), exp_px.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (got_px[k] !== exp_px[k]) begin
                    n_bad++;
                    $display("FAIL bound_px%0d got=%h required=%h", k, got_px[k], exp_px[k]);
                end
            end
            n_cmp++;
            if (got_px[0][23:20] !== 4'b1010) begin
                n_bad++;
                $display("FAIL bound_widths got=%b required=1010", got_px[0][23:20]);
            end
        end
        n_cmp++;
        if (got_fd.size() != 2 || got_fd[0] != 1 || got_fd[1] != 1 || got_err != 0) begin
            n_bad++;
            $display("FAIL bound_frames got_fd=%0d got_err=%0d required two frames of length 1, no errors",
                     got_fd.size(), got_err);
        end
    endtask

    task automatic test_async_reset();
        logic [55:0] last;
        last = exp_px[exp_px.size() - 1];
        clear_obs();
        for (int k = 0; k < 5; k++) send_bit(1'($urandom));
        din = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({pixel_idx, pixel} !== last) begin
            n_bad++;
            $display("FAIL hold_pixel got=%h required=%h", {pixel_idx, pixel}, last);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pixel, pixel_idx, pixel_valid, frame_done, frame_len, bit_err} !== '0) begin
            n_bad++;
            $display("FAIL async_reset got pixel=%h idx=%0d len=%0d required all 0", pixel, pixel_idx, frame_len);
        end
        repeat (3) @(negedge clk);
        din   = 1'b0;
        rst_n = 1'b1;
        model_reset();
        clear_obs();
        for (int k = 0; k < 6; k++) send_bit(1'($urandom));
        seg(1'b0, 200);
        n_cmp++;
        if (got_px.size() != 0 || got_fd.size() != 0 || got_err != 0) begin
            n_bad++;
            $display("FAIL resync_quiet got_px=%0d got_fd=%0d got_err=%0d required all 0",
                     got_px.size(), got_fd.size(), got_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_mid_stream();
        test_glitch();
        test_partial_and_stuck();
        test_boundaries();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ws2812b_rx.md
Name: ws2812b_rx

Overview:
Decodes a WS2812B single-wire NRZ stream, acting as the far end of the LED chain.
- Samples the line, measures high-pulse widths and classifies each bit.
- Assembles 24-bit GGRRBB words and emits each with its LED index.
- Detects frame resets and flags malformed timing.
- Used for loopback checks of the transmitter and as an on-board chain monitor.

Parameters:
FCLK, 100, clock frequency in MHz.
T_BIT_THRESH, 625, ns; a high pulse of at least this width decodes as 1, shorter decodes as 0.
T_HIGH_MIN, 150, ns; a shorter high pulse is a glitch error.
T_HIGH_MAX, 1250, ns; a longer high pulse is a stuck-high error.
T_RST_DET, 50000, ns; a low period of at least this width is a frame reset.
MAX_LEDS, 256, index saturation limit and error bound.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
din  in  1  asynchronous WS2812B data line.
pixel  out  24  last decoded word, MSB received first.
pixel_idx  out  32  index of pixel in the frame, 0-based.
pixel_valid  out  1  one-cycle strobe; pixel and pixel_idx are valid in that cycle.
frame_done  out  1  one-cycle strobe on reset detection after at least one bit.
frame_len  out  32  number of complete words in the last frame; updated with frame_done.
bit_err  out  1  one-cycle strobe on any timing error.

Behaviour:
- Cycle constants (integer division, TCLK = 1000/FCLK ns):
  - C_TH = T_BIT_THRESH/TCLK
  - C_MIN = T_HIGH_MIN/TCLK
  - C_MAX = T_HIGH_MAX/TCLK
  - C_RST = T_RST_DET/TCLK
- Reset (rst_n low, asynchronous): all outputs 0, state SYNC, all counters 0.
- din passes through a 2-FF synchronizer and an edge detector. Rise/fall events are seen 3 cycles after the pin edge.
- One counter of width $clog2(C_RST)+1. It clears on every edge and saturates at C_RST.
- State SYNC: wait until the line has been low for C_RST consecutive cycles, then go to IDLE.
  - No frame_done is issued from SYNC.
  - This prevents decoding a frame joined mid-stream.
- State IDLE: line low, bit_cnt=0, word_cnt=0. On rise go to HIGH.
- State HIGH: count cycles. On fall, with the count taken as the number of sampled-high cycles:
  - count < C_MIN: pulse bit_err, discard the partial word, go to SYNC.
  - otherwise shift in (count >= C_TH) at the LSB of the shift register and increment bit_cnt; go to LOW.
  - If the count reaches C_MAX while still high: pulse bit_err, go to SYNC. SYNC then waits for the line to fall and stay low.
- State LOW: count cycles.
  - On rise go to HIGH, counter cleared.
  - On count == C_RST:
    - pulse frame_done and set frame_len = word_cnt.
    - if bit_cnt != 0 (partial word), also pulse bit_err in the same cycle.
    - go to IDLE.
- Word completion: on the fall that makes bit_cnt reach 24:
  - the next cycle, pixel = shift register, pixel_idx = word_cnt, pixel_valid = 1 for one cycle.
  - bit_cnt then returns to 0 and word_cnt increments.
  - pixel and pixel_idx hold their values until the next word.
- word_cnt saturates at MAX_LEDS. When a word would exceed MAX_LEDS-1: no pixel_valid, bit_err pulses once per extra word.
- frame_done and pixel_valid never coincide. The last word's strobe always precedes the frame_done strobe by at least C_RST cycles.
- Reset asserted mid-word: everything clears immediately. After release the block resynchronises through SYNC.

Decomposition:
- Package ws2812b_pkg holds:
  - the shared timing defaults (T0H/T1H/T0L/T1L/TRST, shared with the transmitter);
  - a function converting ns to cycles for a given FCLK;
  - the rx state enum (SYNC, IDLE, HIGH, LOW).
- Sub-module ws2812b_sync: 2-FF synchronizer plus rise/fall strobes, with its own clk/rst_n.

Test Plan:
1. Line low 60 us after reset, then bits 0x00FF00 with T0H=400, T1H=850, T0L=850, T1L=400 ns, then 60 us low -> pixel=24'h00FF00, pixel_idx=0, one pixel_valid, then frame_done with frame_len=1, no bit_err.
2. Five words 24'hFF0000, 24'h555555, 24'h555555, 24'h555555, 24'hFF0000 back-to-back, then reset -> five pixel_valid strobes with idx 0..4 in order, frame_done with frame_len=5.
3. Decode starts without the initial 60 us low (stream begins mid-word) -> no pixel_valid until after the first 50 us low. After that the next frame decodes correctly and no frame_done is issued for the partial frame.
4. 100 ns glitch high inside a word -> bit_err pulses once, the word is dropped, and no pixel_valid occurs until a reset period plus a clean frame.
5. 12 bits then 60 us low -> bit_err and frame_done in the same cycle, frame_len=0. Then din held high for 2 us -> bit_err when the count reaches C_MAX=125.
6. Boundary widths at FCLK=100: high of 62 cycles -> 1, 61 -> 0. A low of 4999 cycles followed by a rise continues the frame; 5000 cycles -> frame_done. rst_n pulsed low mid-word -> outputs 0 asynchronously.
